mc_controller: RTL

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller_pkg.sv | 43 ++++
 rtl/mc_controller_alu_decoder.sv | 35 +++
 rtl/mc_controller.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_pkg.sv
// Shared definitions for the multicycle controller: FSM states, opcode/funct
// fields and ALU control codes (the ALU uses the same codes).
package mc_controller_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXECUTE,
      S_ALUWB,
      S_BRANCH,
      S_ADDIEXEC,
      S_ADDIWB,
      S_JUMP
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// ALU control decoder: maps the FSM's alu_op and the R-type funct field to an
// ALU function code, flagging whether the funct field was recognised.
module alu_decoder
   import mc_controller_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [2:0] alu_control,
   output logic       funct_legal
);

   always_comb begin
      alu_control = ALU_ADD;
      funct_legal = 1'b0;
      case (alu_op)
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            funct_legal = 1'b1;
            case (funct)
               F_ADD:   alu_control = ALU_ADD;
               F_SUB:   alu_control = ALU_SUB;
               F_AND:   alu_control = ALU_AND;
               F_OR:    alu_control = ALU_OR;
               F_SLT:   alu_control = ALU_SLT;
               default: begin
                  alu_control = ALU_ADD;
                  funct_legal = 1'b0;
               end
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control FSM with configurable FETCH stall cycles.
// Optional overflow trap (ovf input, sticky ovf_err output) under OVF_TRAP_EN.
module mc_controller
   import mc_controller_pkg::*;
#(
   parameter int unsigned FETCH_WAIT = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
`ifdef OVF_TRAP_EN
   input  logic       ovf,
   output logic       ovf_err,
`endif
   output logic [2:0] alu_control,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic       pc_en,
   output logic       iord,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       memto_reg,
   output logic       reg_write,
   output logic       illegal
);

   localparam logic [3:0] WAIT_INIT = 4'(FETCH_WAIT);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       funct_ok_q, funct_ok_d;
   logic [1:0] alu_op;
   logic       funct_legal;
   logic       wb_block;

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct       (funct),
      .alu_control (alu_control),
      .funct_legal (funct_legal)
   );

`ifdef OVF_TRAP_EN
   logic ovf_pend_q, ovf_pend_d;
   logic ovf_err_q, ovf_err_d;
   logic ovf_hit;

   // Overflow is captured with the exec state so the writeback state already sees it
   always_comb begin
      ovf_hit = 1'b0;
      if (state_q == S_ADDIEXEC)
         ovf_hit = ovf;
      else if (state_q == S_EXECUTE)
         ovf_hit = ovf && (funct == F_ADD || funct == F_SUB);
      ovf_pend_d = ovf_pend_q;
      if (state_q == S_ADDIEXEC || state_q == S_EXECUTE)
         ovf_pend_d = ovf_hit;
      ovf_err_d = ovf_err_q | ovf_hit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_pend_q <= 1'b0;
         ovf_err_q  <= 1'b0;
      end else begin
         ovf_pend_q <= ovf_pend_d;
         ovf_err_q  <= ovf_err_d;
      end
   end

   assign wb_block = ovf_pend_q;
   assign ovf_err  = ovf_err_q;
`else
   assign wb_block = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_FETCH;
         cnt_q      <= WAIT_INIT;
         funct_ok_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         funct_ok_q <= funct_ok_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      funct_ok_d = funct_ok_q;
      alu_op     = ALUOP_ADD;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_src     = 2'b00;
      pc_en      = 1'b0;
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      memto_reg  = 1'b0;
      reg_write  = 1'b0;
      illegal    = 1'b0;
      case (state_q)
         S_FETCH: begin
            // rst_n gating keeps write enables low while reset holds FETCH
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (rst_n) begin
               alu_src_b = 2'b01;
               ir_write  = 1'b1;
               pc_en     = 1'b1;
               cnt_d     = WAIT_INIT;
               state_d   = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEXEC;
               OP_J:         state_d = S_JUMP;
               default: begin
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            iord    = 1'b1;
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            memto_reg = 1'b1;
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_EXECUTE: begin
            alu_src_a  = 1'b1;
            alu_op     = ALUOP_FUNCT;
            funct_ok_d = funct_legal;
            state_d    = S_ALUWB;
         end
         S_ALUWB: begin
            reg_dst   = 1'b1;
            reg_write = funct_ok_q & ~wb_block;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_SUB;
            pc_src    = 2'b01;
            pc_en     = zero;
            state_d   = S_FETCH;
         end
         S_ADDIEXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write = ~wb_block;
            state_d   = S_FETCH;
         end
         S_JUMP: begin
            pc_src  = 2'b10;
            pc_en   = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

endmodule
